// File: rtl/alu_operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer_pkg
// Shared opcode and state definitions for the 4-bit ALU datapath and its
// operand sequencer. ALU benches and the sequencer import the same encodings.
//
// Contents:
//   OP_ADD..OP_RSV1  3-bit opcode encodings understood by the ALU
//   state_t          sequencer FSM states S_OP..S_EXEC, S_OUT
// -----------------------------------------------------------------------------
package alu_operand_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_sequencer_op_decode.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer_op_decode
// Combinational opcode classifier for the operand sequencer.
//
// Ports:
//   op           in  OPW  opcode to classify
//   is_unary     out 1    opcode takes only operand A (NOT)
//   is_reserved  out 1    opcode is one of the two reserved encodings
// -----------------------------------------------------------------------------
module alu_operand_sequencer_op_decode
    import alu_operand_sequencer_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] op,
    output logic           is_unary,
    output logic           is_reserved
);

    assign is_unary    = (op == OPW'(OP_NOT));
    assign is_reserved = (op == OPW'(OP_RSV0)) || (op == OPW'(OP_RSV1));

endmodule

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
// Upstream feeder for the combinational 4-bit ALU. Collects an opcode beat,
// operand A and (except for NOT) operand B from a valid/ready stream, holds
// them steady on the ALU inputs, captures the ALU result one cycle later and
// offers it on a valid/ready output port.
//
// Handshake: a beat moves on any posedge where valid and ready are both high;
// valid may not depend on ready, and a source holds data stable while
// valid is high and ready is low.
//
// Build option: ALU_SEQ_OVERLAP_EN -- when defined, an opcode beat may be
// accepted in the same cycle the pending result drains (in_ready follows
// out_ready in S_OUT), removing the idle S_OP cycle between operations.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready/in_data   beat input (opcode / A / B)
//   alu_op/alu_x/alu_y          registered ALU inputs (alu_y=0 for NOT)
//   alu_z                       combinational ALU result
//   out_valid/out_ready/out_data/out_err   result output
//   state                       current FSM state (debug)
// -----------------------------------------------------------------------------
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    input  logic [W-1:0]   alu_z,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_err,
    output logic [2:0]     state
);

    state_t         cur_state;
    state_t         nxt_state;
    logic           xfer;
    logic           op_load;
    logic [OPW-1:0] dec_op;
    logic           dec_unary;
    logic           dec_reserved;

    // In S_A the opcode is already registered; everywhere else the opcode of
    // interest is the one arriving on in_data.
    assign dec_op = (cur_state == S_A) ? alu_op : in_data[OPW-1:0];

    alu_operand_sequencer_op_decode #(
        .OPW (OPW)
    ) u_decode (
        .op          (dec_op),
        .is_unary    (dec_unary),
        .is_reserved (dec_reserved)
    );

    always_comb begin
        in_ready = 1'b0;
        case (cur_state)
            S_OP, S_A, S_B: in_ready = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
            S_OUT:          in_ready = out_ready;
`else
            S_OUT:          in_ready = 1'b0;
`endif
            default:        in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid & in_ready;
    assign out_valid = (cur_state == S_OUT);
    assign state     = cur_state;

    // An accepted beat in S_OUT can only exist in the overlap build, and it
    // is always an opcode beat.
    assign op_load = xfer && ((cur_state == S_OP) || (cur_state == S_OUT));

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_OP: begin
                if (xfer) nxt_state = dec_reserved ? S_OUT : S_A;
            end
            S_A: begin
                if (xfer) nxt_state = dec_unary ? S_EXEC : S_B;
            end
            S_B: begin
                if (xfer) nxt_state = S_EXEC;
            end
            S_EXEC: nxt_state = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (xfer) nxt_state = dec_reserved ? S_OUT : S_A;
                    else      nxt_state = S_OP;
                end
            end
            default: nxt_state = S_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_OP;
        else       cur_state <= nxt_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op   <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            if (op_load) begin
                alu_op <= in_data[OPW-1:0];
                // Reserved opcodes never reach the ALU result path; the error
                // result is formed here and presented directly in S_OUT.
                if (dec_reserved) begin
                    out_data <= '0;
                    out_err  <= 1'b1;
                end
            end
            if (xfer && (cur_state == S_A)) begin
                alu_x <= in_data;
                if (dec_unary) alu_y <= '0;
            end
            if (xfer && (cur_state == S_B)) begin
                alu_y <= in_data;
            end
            if (cur_state == S_EXEC) begin
                out_data <= alu_z;
                out_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    localparam int W   = 4;
    localparam int OPW = 3;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_x;
    logic [W-1:0]   alu_y;
    logic [W-1:0]   alu_z;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_err;
    logic [2:0]     state;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];

    alu_operand_sequencer #(.W(W), .OPW(OPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .alu_op    (alu_op),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .state     (state)
    );

    // Behavioural ALU hanging off the sequencer outputs.
    always_comb begin
        alu_z = '0;
        case (alu_op)
            3'b000: alu_z = alu_x + alu_y;
            3'b001: alu_z = alu_x - alu_y;
            3'b010: alu_z = alu_x & alu_y;
            3'b011: alu_z = alu_x | alu_y;
            3'b100: alu_z = alu_x ^ alu_y;
            3'b101: alu_z = ~alu_x;
            default: alu_z = '0;
        endcase
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input string tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic exp_err);
        int n;
        logic [W-1:0] e;
        n = 0;
        e = exp_q.pop_front();
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(e));
        chk({tag, "_err"},   32'(out_err),   32'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_bin(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] exp, input string tag);
        exp_q.push_back(exp);
        send_beat({1'b0, op}, tag);
        send_beat(a, tag);
        send_beat(b, tag);
        wait_result(tag, 1'b0);
        chk({tag, "_back_to_op"}, 32'(state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_alu_op",    32'(alu_op),    32'd0);

        // 1. NOT with latency check: result valid two cycles after the A beat
        exp_q.push_back(4'b0101);
        send_beat(4'b0101, "not");
        send_beat(4'b1010, "not");
        chk("not_alu_x",       32'(alu_x),     32'b1010);
        chk("not_alu_y",       32'(alu_y),     32'b0000);
        chk("not_state_exec",  32'(state),     32'd3);
        chk("not_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("not_valid_t2",    32'(out_valid), 32'd1);
        wait_result("not", 1'b0);

        // 2. ADD wrap and SUB wrap
        run_bin(3'b000, 4'b1111, 4'b0001, 4'b0000, "add_wrap");
        run_bin(3'b001, 4'b0011, 4'b0101, 4'b1110, "sub_wrap");

        // 3. Reserved opcodes: result next cycle, no operand beats
        exp_q.push_back(4'b0000);
        send_beat(4'b0110, "rsv0");
        chk("rsv0_state_out", 32'(state),     32'd4);
        chk("rsv0_valid_t1",  32'(out_valid), 32'd1);
        wait_result("rsv0", 1'b1);
        chk("rsv0_no_operand", 32'(state), 32'd0);
        exp_q.push_back(4'b0000);
        send_beat(4'b0111, "rsv1");
        wait_result("rsv1", 1'b1);

        // 4a. in_valid low 3 cycles between beats
        exp_q.push_back(4'b1000);
        send_beat(4'b0010, "stall");
        send_beat(4'b1100, "stall");
        repeat (3) tick();
        chk("stall_hold_state", 32'(state), 32'd2);
        chk("stall_hold_x",     32'(alu_x), 32'b1100);
        send_beat(4'b1010, "stall");
        wait_result("stall", 1'b0);

        // 4b. out_ready low 4 cycles: result held, no beat accepted
        exp_q.push_back(4'b0101);
        send_beat(4'b0100, "bp");
        send_beat(4'b0110, "bp");
        send_beat(4'b0011, "bp");
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_data_hold",  32'(out_data),  32'b0101);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
            tick();
        end
        wait_result("bp", 1'b0);

        // 5. Reset in S_B wins over a simultaneous beat
        send_beat(4'b0010, "rst_mid");
        send_beat(4'b1100, "rst_mid");
        chk("rst_mid_in_b", 32'(state), 32'd2);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_state",  32'(state),     32'd0);
        chk("rst_mid_op",     32'(alu_op),    32'd0);
        chk("rst_mid_x",      32'(alu_x),     32'd0);
        chk("rst_mid_y",      32'(alu_y),     32'd0);
        chk("rst_mid_data",   32'(out_data),  32'd0);
        chk("rst_mid_valid",  32'(out_valid), 32'd0);
        chk("rst_mid_err",    32'(out_err),   32'd0);
        run_bin(3'b011, 4'b1001, 4'b0110, 4'b1111, "or_fresh");

        // 6. Opcode beat offered in the draining S_OUT cycle
        exp_q.push_back(4'b0011);
        send_beat(4'b0000, "ovl_first");
        send_beat(4'b0001, "ovl_first");
        send_beat(4'b0010, "ovl_first");
        tick();
        chk("ovl_pending", 32'(out_valid), 32'd1);
        chk("ovl_data",    32'(out_data),  32'b0011);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b0101;
`ifdef ALU_SEQ_OVERLAP_EN
        chk("ovl_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("ovl_state_a", 32'(state),  32'd1);
        chk("ovl_op",      32'(alu_op), 32'b101);
`else
        chk("ovl_in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("ovl_state_op", 32'(state), 32'd0);
        chk("ovl_op_kept",  32'(alu_op), 32'b000);
        tick();
        in_valid = 1'b0;
        chk("ovl_state_a", 32'(state),  32'd1);
        chk("ovl_op",      32'(alu_op), 32'b101);
`endif
        exp_q.push_back(4'b1100);
        send_beat(4'b0011, "ovl_not");
        wait_result("ovl_not", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
